planet_regfile: RTL and testbench

PLANET_REGFILE -- requirements
Module: planet_regfile

---
 rtl/planet_regfile.sv | 86 ++++++++
 tb/tb_planet_regfile.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/planet_regfile.sv
// planet_regfile: shared word store for the planet simulator, host port plus six FSM ports
module planet_regfile #(
   parameter int DEPTH       = 114,
   parameter int MAX_PLANETS = 10
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        AVL_CS,
   input  logic        AVL_READ,
   input  logic        AVL_WRITE,
   input  logic [6:0]  AVL_ADDR,
   input  logic [31:0] AVL_WRITEDATA,
   output logic [31:0] AVL_READDATA,
   input  logic [1:0]  FSM_re,
   input  logic [1:0]  FSM_we,
   input  logic [31:0] ADDR1,
   input  logic [31:0] ADDR2,
   input  logic [31:0] ADDR3,
   input  logic [31:0] ADDR4,
   input  logic [31:0] ADDR5,
   input  logic [31:0] ADDR6,
   input  logic [31:0] DATA1,
   input  logic [31:0] DATA2,
   input  logic [31:0] DATA3,
   input  logic [31:0] DATA4,
   input  logic [31:0] DATA5,
   input  logic [31:0] DATA6,
   output logic [31:0] DATA1in,
   output logic [31:0] DATA2in,
   output logic [31:0] DATA3in,
   output logic [31:0] DATA4in,
   output logic [31:0] DATA5in,
   output logic [31:0] DATA6in,
   input  logic        clear_accs,
   input  logic        FSM_DONE,
   output logic        FSM_START,
   output logic [31:0] G,
   output logic [3:0]  PLANET_NUM
);
   localparam int ACC_LO = 4 + 8 * MAX_PLANETS;
   localparam int ACC_HI = 3 + 11 * MAX_PLANETS;
   logic [31:0] mem [DEPTH];
   logic [31:0] addr [6];
   logic [31:0] wdata [6];
   logic [31:0] rdata [6];
   logic [5:0]  re_en, we_en, ok;
   logic        avl_ok;
   always_comb begin
      addr   = '{ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6};
      wdata  = '{DATA1, DATA2, DATA3, DATA4, DATA5, DATA6};
      re_en  = {{3{FSM_re[1]}}, {3{FSM_re[0]}}};
      we_en  = {{3{FSM_we[1]}}, {3{FSM_we[0]}}};
      avl_ok = {25'd0, AVL_ADDR} < DEPTH;
      for (int k = 0; k < 6; k++) ok[k] = addr[k] < DEPTH;
   end
   // later assignments win: host, then FSM ports in order, then clear_accs, then FSM_DONE
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         for (int k = 0; k < 6; k++) rdata[k] <= '0;
         AVL_READDATA <= '0;
      end else begin
         if (AVL_CS && AVL_READ) AVL_READDATA <= avl_ok ? mem[AVL_ADDR] : '0;
         for (int k = 0; k < 6; k++)
            if (re_en[k]) rdata[k] <= ok[k] ? mem[addr[k][6:0]] : '0;
         if (AVL_CS && AVL_WRITE && avl_ok) begin
            mem[AVL_ADDR] <= AVL_WRITEDATA;
            if (AVL_ADDR == 7'd2 && AVL_WRITEDATA == 32'd1) mem[3] <= '0;
         end
         for (int k = 0; k < 6; k++)
            if (we_en[k] && ok[k]) mem[addr[k][6:0]] <= wdata[k];
         if (clear_accs)
            for (int i = ACC_LO; i <= ACC_HI; i++) mem[i] <= '0;
         if (FSM_DONE) mem[3] <= 32'd1;
      end
   end
   assign DATA1in    = rdata[0];
   assign DATA2in    = rdata[1];
   assign DATA3in    = rdata[2];
   assign DATA4in    = rdata[3];
   assign DATA5in    = rdata[4];
   assign DATA6in    = rdata[5];
   assign G          = mem[0];
   assign PLANET_NUM = mem[1][3:0];
   assign FSM_START  = mem[2][0];
endmodule

// File: tb/tb_planet_regfile.sv
// tb_planet_regfile: scoreboard bench for planet_regfile
module tb_planet_regfile;
   logic        CLK = 1'b0;
   logic        RESET, AVL_CS, AVL_READ, AVL_WRITE, clear_accs, FSM_DONE, FSM_START;
   logic [6:0]  AVL_ADDR;
   logic [31:0] AVL_WRITEDATA, AVL_READDATA, G;
   logic [1:0]  FSM_re, FSM_we;
   logic [3:0]  PLANET_NUM;
   logic [31:0] addr [6];
   logic [31:0] wdat [6];
   logic [31:0] din [6];
   typedef struct {
      string       tag;
      int          src;
      logic [31:0] exp;
   } exp_t;
   exp_t q[$];
   int checks = 0, errors = 0;
   always #5 CLK = ~CLK;
   planet_regfile dut (
      .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
      .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
      .FSM_re(FSM_re), .FSM_we(FSM_we),
      .ADDR1(addr[0]), .ADDR2(addr[1]), .ADDR3(addr[2]), .ADDR4(addr[3]), .ADDR5(addr[4]), .ADDR6(addr[5]),
      .DATA1(wdat[0]), .DATA2(wdat[1]), .DATA3(wdat[2]), .DATA4(wdat[3]), .DATA5(wdat[4]), .DATA6(wdat[5]),
      .DATA1in(din[0]), .DATA2in(din[1]), .DATA3in(din[2]), .DATA4in(din[3]), .DATA5in(din[4]), .DATA6in(din[5]),
      .clear_accs(clear_accs), .FSM_DONE(FSM_DONE), .FSM_START(FSM_START), .G(G), .PLANET_NUM(PLANET_NUM)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] out_of(input int s);
      return s < 6 ? din[s] : AVL_READDATA;
   endfunction
   task automatic push(input int s, input logic [31:0] e, input string tag);
      q.push_back('{tag, s, e});
   endtask
   // every queued expectation belongs to the edge just taken
   task automatic tick();
      exp_t e;
      @(posedge CLK);
      #1;
      while (q.size() > 0) begin
         e = q.pop_front();
         check(e.tag, out_of(e.src), e.exp);
      end
   endtask
   task automatic idle();
      AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0;
      FSM_re = 0; FSM_we = 0; clear_accs = 0; FSM_DONE = 0;
   endtask
   task automatic host_wr(input logic [6:0] a, input logic [31:0] d);
      AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = a; AVL_WRITEDATA = d;
      tick();
      idle();
   endtask
   task automatic host_rd(input logic [6:0] a, input logic [31:0] e, input string tag);
      AVL_CS = 1; AVL_READ = 1; AVL_ADDR = a;
      push(6, e, tag);
      tick();
      idle();
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   initial begin
      idle();
      RESET = 1; AVL_ADDR = 0; AVL_WRITEDATA = 0;
      addr = '{0, 0, 0, 0, 0, 0};
      wdat = '{0, 0, 0, 0, 0, 0};
      tick();
      tick();
      RESET = 0;
      check("rst_G", G, 0);
      check("rst_num", {28'd0, PLANET_NUM}, 0);
      check("rst_start", {31'd0, FSM_START}, 0);
      check("rst_d1", din[0], 0);
      check("rst_avl", AVL_READDATA, 0);
      // host loads, then all six ports read
      host_wr(0, 32'h40800000);
      check("G_wr", G, 32'h40800000);
      host_wr(1, 32'd2);
      check("num_wr", {28'd0, PLANET_NUM}, 2);
      host_wr(24, 32'h11111111);
      host_wr(25, 32'h22222222);
      host_wr(54, 32'h33333333);
      host_wr(55, 32'h44444444);
      addr = '{0, 1, 24, 25, 54, 55};
      FSM_re = 3;
      push(0, 32'h40800000, "rd_p1"); push(1, 32'd2, "rd_p2"); push(2, 32'h11111111, "rd_p3");
      push(3, 32'h22222222, "rd_p4"); push(4, 32'h33333333, "rd_p5"); push(5, 32'h44444444, "rd_p6");
      tick();
      idle();
      addr = '{1, 0, 25, 24, 55, 54};
      push(0, 32'h40800000, "hold_p1"); push(3, 32'h22222222, "hold_p4"); push(5, 32'h44444444, "hold_p6");
      tick();
      FSM_re = 2;
      push(0, 32'h40800000, "grp2_p1"); push(2, 32'h11111111, "grp2_p3");
      push(3, 32'h11111111, "grp2_p4"); push(4, 32'h44444444, "grp2_p5"); push(5, 32'h33333333, "grp2_p6");
      tick();
      idle();
      // read-during-write returns old data; out-of-range ports read 0 and do not write
      addr = '{30, 200, 200, 0, 0, 0};
      wdat = '{32'hCAFE0001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0};
      FSM_re = 1; FSM_we = 1;
      push(0, 32'h0, "rdw_old"); push(1, 32'h0, "oob_rd2"); push(2, 32'h0, "oob_rd3");
      tick();
      idle();
      FSM_re = 1;
      push(0, 32'hCAFE0001, "rdw_new");
      tick();
      idle();
      host_rd(72, 0, "oob_alias");
      // two ports plus host on one word: highest port wins
      addr = '{24, 24, 200, 0, 0, 0};
      wdat = '{32'h3F800000, 32'hBF800000, 0, 0, 0, 0};
      FSM_we = 1;
      AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 24; AVL_WRITEDATA = 0;
      tick();
      idle();
      host_rd(24, 32'hBF800000, "wr_prio");
      addr = '{0, 0, 0, 40, 200, 40};
      wdat = '{0, 0, 0, 32'd1, 32'd5, 32'd6};
      FSM_we = 2;
      tick();
      idle();
      host_rd(40, 32'd6, "wr_p6_wins");
      addr = '{32'h80000018, 200, 200, 0, 0, 0};
      wdat = '{32'h12345678, 0, 0, 0, 0, 0};
      FSM_we = 1;
      tick();
      idle();
      host_rd(24, 32'hBF800000, "hi_bits_ign");
      host_wr(120, 32'd5);
      host_rd(120, 0, "avl_oob");
      // clear_accs beats FSM and host writes into the ACC range
      for (int i = 84; i <= 113; i++) host_wr(7'(i), 32'h3F800000);
      host_rd(100, 32'h3F800000, "acc_pre");
      clear_accs = 1; FSM_we = 2;
      addr = '{0, 0, 0, 84, 200, 200};
      wdat = '{0, 0, 0, 32'd5, 32'd9, 32'd9};
      AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 113; AVL_WRITEDATA = 32'd7;
      tick();
      idle();
      for (int i = 84; i <= 113; i++) host_rd(7'(i), 0, $sformatf("acc_clr_%0d", i));
      host_rd(24, 32'hBF800000, "acc_keep24");
      // DONE / START handshake
      FSM_DONE = 1;
      AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 3; AVL_WRITEDATA = 32'd7;
      tick();
      idle();
      host_rd(3, 32'd1, "done_prio");
      host_wr(2, 32'd1);
      check("start_out", {31'd0, FSM_START}, 1);
      host_rd(3, 0, "start_clr");
      FSM_DONE = 1;
      AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 2; AVL_WRITEDATA = 32'd1;
      tick();
      idle();
      host_rd(3, 32'd1, "done_vs_start");
      host_wr(2, 32'd1);
      FSM_DONE = 1;
      tick();
      idle();
      host_rd(3, 32'd1, "done_pulse");
      push(6, 32'd1, "avl_hold");
      tick();
      // reset wins over reads and a host write in the same edge
      addr = '{0, 1, 24, 25, 54, 55};
      FSM_re = 3;
      AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 5; AVL_WRITEDATA = 32'h1234;
      RESET = 1;
      for (int k = 0; k < 6; k++) push(k, 0, $sformatf("rst_rd_p%0d", k + 1));
      push(6, 0, "rst_avl2");
      tick();
      RESET = 0;
      idle();
      check("rst2_G", G, 0);
      check("rst2_num", {28'd0, PLANET_NUM}, 0);
      check("rst2_start", {31'd0, FSM_START}, 0);
      host_rd(5, 0, "rst_wr_drop");
      host_rd(24, 0, "rst_w24");
      host_rd(3, 0, "rst_w3");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
